fetch_stage: RTL and testbench

Instruction-fetch stage of the SimpleRISC pipeline. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word plus its PC into the IF/ID pipeline register for decode. Supports hazard-unit stalls, branch redirect with flush, and stops fetching on `hlt` or an out-of-range PC.

---
 rtl/simplerisc_pkg.sv | 12 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared SimpleRISC opcodes, fetch FSM states and IF/ID record.
package simplerisc_pkg;
  localparam logic [4:0] OP_NOP = 5'b01101;
  localparam logic [4:0] OP_HLT = 5'b11111;
  localparam logic [31:0] NOP_INSN = {OP_NOP, 27'b0};
  typedef enum logic {RUN, HALT} fetch_state_t;
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, otherwise holds.
module if_id_reg
  import simplerisc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     insn_d,
  input  logic [PC_W-1:0] pc_d,
  output logic [31:0]     insn,
  output logic [PC_W-1:0] pc,
  output logic            valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn  <= NOP_INSN;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      insn  <= NOP_INSN;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      insn  <= insn_d;
      pc    <= pc_d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, RUN/HALT control and fetch counter feeding the IF/ID register.
module fetch_stage
  import simplerisc_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] PC_INC     = 1,
  parameter int              IMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_insn_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [31:0]     if_insn_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic            if_valid_o,
  output logic            halted_o,
  output logic            fault_o,
  output logic [31:0]     fetch_count_o
);
  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic            run, out_of_range, load, flush;
  assign imem_addr_o  = pc_q;
  assign halted_o     = state == HALT;
  assign run          = state == RUN;
  assign out_of_range = pc_q >= PC_W'(IMEM_DEPTH);
  assign load         = !branch_taken_i && run && !stall_i && !out_of_range;
  // HALT ignores stall and bubbles IF/ID every cycle until a branch
  assign flush        = branch_taken_i || !run || (!stall_i && out_of_range);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      fault_o       <= 1'b0;
      fetch_count_o <= '0;
    end else if (branch_taken_i) begin
      state <= RUN;
      pc_q  <= branch_target_i;
    end else if (run && !stall_i) begin
      if (out_of_range) begin
        state   <= HALT;
        fault_o <= 1'b1;
      end else begin
        pc_q          <= pc_q + PC_INC;
        fetch_count_o <= fetch_count_o + 32'd1;
        state         <= imem_insn_i[31:27] == OP_HLT ? HALT : RUN;
      end
    end
  end
  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .flush (flush),
    .insn_d(imem_insn_i),
    .pc_d  (pc_q),
    .insn  (if_insn_o),
    .pc    (if_pc_o),
    .valid (if_valid_o)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset corner cases, then random run against a reference model.
module tb_fetch_stage;
  import simplerisc_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_insn, branch_target, if_insn, if_pc, fetch_count;
  logic stall, branch_taken, if_valid, halted, fault;
  logic [31:0] mem [256];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  assign imem_insn = (imem_addr < 256) ? mem[imem_addr[7:0]] : 32'h0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr), .imem_insn_i(imem_insn),
    .stall_i(stall), .branch_taken_i(branch_taken), .branch_target_i(branch_target),
    .if_insn_o(if_insn), .if_pc_o(if_pc), .if_valid_o(if_valid), .halted_o(halted),
    .fault_o(fault), .fetch_count_o(fetch_count)
  );

  typedef struct {
    bit stall; bit br; logic [31:0] tgt;
    logic [31:0] addr; logic [31:0] ifpc; bit valid; bit halt; bit flt; logic [31:0] cnt;
  } vec_t;
  vec_t tbl [24];

  function automatic vec_t mk(bit s, bit b, logic [31:0] t, logic [31:0] a, logic [31:0] p,
                              bit v, bit h, bit f, logic [31:0] c);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.addr = a; r.ifpc = p;
    r.valid = v; r.halt = h; r.flt = f; r.cnt = c;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [31:0] addr, logic [31:0] ifpc, logic [31:0] insn,
                            bit valid, bit halt, bit flt, logic [31:0] cnt);
    vectors++;
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".if_pc"}, if_pc, ifpc);
    chk({tag, ".if_insn"}, if_insn, insn);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(valid));
    chk({tag, ".halted"}, 32'(halted), 32'(halt));
    chk({tag, ".fault"}, 32'(fault), 32'(flt));
    chk({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  task automatic cycle(bit s, bit b, logic [31:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference model state
  logic [31:0] m_pc, m_insn, m_ifpc, m_cnt;
  bit m_valid, m_halt, m_fault;

  task automatic model_reset();
    m_pc = 0; m_insn = NOP_INSN; m_ifpc = 0; m_cnt = 0;
    m_valid = 0; m_halt = 0; m_fault = 0;
  endtask

  task automatic model_step(bit s, bit b, logic [31:0] t);
    logic [31:0] w;
    if (b) begin
      m_pc = t; m_insn = NOP_INSN; m_ifpc = 0; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      m_insn = NOP_INSN; m_ifpc = 0; m_valid = 0;
    end else if (!s) begin
      if (m_pc >= 256) begin
        m_insn = NOP_INSN; m_ifpc = 0; m_valid = 0; m_fault = 1; m_halt = 1;
      end else begin
        w = mem[m_pc[7:0]];
        m_insn = w; m_ifpc = m_pc; m_valid = 1;
        m_pc = m_pc + 1; m_cnt = m_cnt + 1;
        if (w[31:27] == 5'b11111) m_halt = 1;
      end
    end
  endtask

  initial begin
    logic [31:0] r, t;
    bit s, b;
    stall = 0; branch_taken = 0; branch_target = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    for (int i = 0; i < 4; i++) mem[i] = 32'h11111111;
    mem[6] = 32'hF8000000;
    tbl[0]  = mk(0, 0, 0,     1,     0,     1, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0,     2,     1,     1, 0, 0, 2);
    tbl[2]  = mk(1, 0, 0,     2,     1,     1, 0, 0, 2);
    tbl[3]  = mk(1, 0, 0,     2,     1,     1, 0, 0, 2);
    tbl[4]  = mk(1, 0, 0,     2,     1,     1, 0, 0, 2);
    tbl[5]  = mk(0, 0, 0,     3,     2,     1, 0, 0, 3);
    tbl[6]  = mk(0, 0, 0,     4,     3,     1, 0, 0, 4);
    tbl[7]  = mk(0, 0, 0,     5,     4,     1, 0, 0, 5);
    tbl[8]  = mk(0, 1, 'h20,  'h20,  0,     0, 0, 0, 5);
    tbl[9]  = mk(0, 0, 0,     'h21,  'h20,  1, 0, 0, 6);
    tbl[10] = mk(0, 1, 4,     4,     0,     0, 0, 0, 6);
    tbl[11] = mk(0, 0, 0,     5,     4,     1, 0, 0, 7);
    tbl[12] = mk(0, 0, 0,     6,     5,     1, 0, 0, 8);
    tbl[13] = mk(0, 0, 0,     7,     6,     1, 1, 0, 9);
    tbl[14] = mk(0, 0, 0,     7,     0,     0, 1, 0, 9);
    tbl[15] = mk(1, 0, 0,     7,     0,     0, 1, 0, 9);
    tbl[16] = mk(0, 1, 0,     0,     0,     0, 0, 0, 9);
    tbl[17] = mk(1, 1, 'h10,  'h10,  0,     0, 0, 0, 9);
    tbl[18] = mk(0, 0, 0,     'h11,  'h10,  1, 0, 0, 10);
    tbl[19] = mk(0, 1, 256,   256,   0,     0, 0, 0, 10);
    tbl[20] = mk(0, 0, 0,     256,   0,     0, 1, 1, 10);
    tbl[21] = mk(0, 0, 0,     256,   0,     0, 1, 1, 10);
    tbl[22] = mk(0, 1, 3,     3,     0,     0, 0, 1, 10);
    tbl[23] = mk(0, 0, 0,     4,     3,     1, 0, 1, 11);

    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, NOP_INSN, 0, 0, 0, 0);
    rst_n = 1;
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].stall, tbl[i].br, tbl[i].tgt);
      check_outs($sformatf("row%0d", i), tbl[i].addr, tbl[i].ifpc,
                 tbl[i].valid ? mem[tbl[i].ifpc[7:0]] : NOP_INSN,
                 tbl[i].valid, tbl[i].halt, tbl[i].flt, tbl[i].cnt);
    end

    // fault into HALT, then asynchronous reset with no clock edge
    cycle(0, 1, 256);
    cycle(0, 0, 0);
    check_outs("fault_halt", 256, 0, NOP_INSN, 0, 1, 1, 11);
    rst_n = 0;
    #1;
    check_outs("rst_in_halt", 0, 0, NOP_INSN, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    // reset while stalled mid-run
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check_outs("stall_pre_rst", 2, 1, mem[1], 1, 0, 0, 2);
    rst_n = 0;
    #1;
    check_outs("rst_in_stall", 0, 0, NOP_INSN, 0, 0, 0, 0);

    // random run against the reference model
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      if ($urandom_range(15) == 0) r[31:27] = 5'b11111;
      mem[i] = r;
    end
    @(negedge clk);
    stall = 0; branch_taken = 0;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      s = $urandom_range(3) == 0;
      b = $urandom_range(7) == 0;
      t = $urandom_range(300);
      model_step(s, b, t);
      cycle(s, b, t);
      check_outs($sformatf("rand%0d", i), m_pc, m_ifpc, m_insn, m_valid, m_halt, m_fault, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
